// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - address map, status bits and tx FSM encoding for mmio_ctrl
package mmio_pkg;

  localparam logic [31:0] ADDR_STATUS  = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX      = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX      = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYC     = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTRET = 32'h8000_0014;
  localparam logic [31:0] ADDR_CNT_RST = 32'h8000_0018;

  // The I/O window is one 4 KiB page; only aligned words inside it can hit.
  localparam logic [19:0] WINDOW_PAGE = 20'h80000;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_RX_VALID = 1;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_UNMAPPED,
    SEL_STATUS,
    SEL_RX,
    SEL_TX,
    SEL_CYC,
    SEL_INSTRET,
    SEL_CNT_RST
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    if (addr[31:12] != WINDOW_PAGE || addr[1:0] != 2'b00) begin
      sel = SEL_NONE;
    end else begin
      case (addr)
        ADDR_STATUS:  sel = SEL_STATUS;
        ADDR_RX:      sel = SEL_RX;
        ADDR_TX:      sel = SEL_TX;
        ADDR_CYC:     sel = SEL_CYC;
        ADDR_INSTRET: sel = SEL_INSTRET;
        ADDR_CNT_RST: sel = SEL_CNT_RST;
        default:      sel = SEL_UNMAPPED;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_counters.sv
// rtl/mmio_counters.sv - free-running cycle and retired-instruction counters with shared clear
module mmio_counters
  import mmio_pkg::*;
#(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_retire,
  output logic [W_SIZE-1:0] o_cycle,
  output logic [W_SIZE-1:0] o_instret
);

  logic [W_SIZE-1:0] r_cycle;
  logic [W_SIZE-1:0] r_instret;

  // Clear has priority over the increment made in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else if (i_clr) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + W_SIZE'(1);
      if (i_retire) begin
        r_instret <= r_instret + W_SIZE'(1);
      end
    end
  end

  assign o_cycle   = r_cycle;
  assign o_instret = r_instret;

endmodule

// File: rtl/mmio_ctrl.sv
// rtl/mmio_ctrl.sv - X/M-stage I/O window decode, UART tx holding buffer, rx read path, counters
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_xm,
  input  logic              st_xm,
  input  logic [W_SIZE-1:0] addr_xm,
  input  logic [W_SIZE-1:0] wdata_xm,
  input  logic              inst_retire,
  output logic              uart_tx_valid,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_ready,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_rx_ready,
  output logic              stall,
  output logic              mmio_hit_wb,
  output logic [W_SIZE-1:0] mmio_rdata_wb
);

  reg_sel_e          w_sel;
  logic              w_ld_hit;
  logic              w_tx_st;
  logic              w_cnt_clr;
  logic [W_SIZE-1:0] w_rdata;
  logic [W_SIZE-1:0] w_cycle;
  logic [W_SIZE-1:0] w_instret;
  logic              w_unused_wdata;

  tx_state_e         r_state;
  logic [7:0]        r_tx_byte;
  logic              r_hit;
  logic [W_SIZE-1:0] r_rdata;

  assign w_sel     = decode_addr(addr_xm[31:0]);
  assign w_ld_hit  = ld_xm && (w_sel != SEL_NONE);
  assign w_tx_st   = st_xm && (w_sel == SEL_TX);
  assign w_cnt_clr = st_xm && (w_sel == SEL_CNT_RST);

  assign w_unused_wdata = &{1'b0, wdata_xm[W_SIZE-1:8]};

  // A tx store only waits when the buffer is occupied and the UART is not draining it now.
  assign stall         = w_tx_st && (r_state == TX_FULL) && !uart_tx_ready;
  assign uart_rx_ready = ld_xm && (w_sel == SEL_RX) && uart_rx_valid;

  assign uart_tx_valid = (r_state == TX_FULL);
  assign uart_tx_data  = r_tx_byte;

  mmio_counters #(
    .W_SIZE (W_SIZE)
  ) u_counters (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_cnt_clr),
    .i_retire  (inst_retire),
    .o_cycle   (w_cycle),
    .o_instret (w_instret)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= TX_EMPTY;
      r_tx_byte <= 8'h00;
    end else begin
      case (r_state)
        TX_EMPTY: begin
          if (w_tx_st) begin
            r_tx_byte <= wdata_xm[7:0];
            r_state   <= TX_FULL;
          end
        end
        TX_FULL: begin
          if (uart_tx_ready) begin
            if (w_tx_st) begin
              r_tx_byte <= wdata_xm[7:0];
            end else begin
              r_state <= TX_EMPTY;
            end
          end
        end
        default: r_state <= TX_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_STATUS: begin
        w_rdata[STAT_TX_EMPTY] = (r_state == TX_EMPTY);
        w_rdata[STAT_RX_VALID] = uart_rx_valid;
      end
      SEL_RX:      w_rdata[7:0] = uart_rx_data;
      SEL_CYC:     w_rdata      = w_cycle;
      SEL_INSTRET: w_rdata      = w_instret;
      default:     w_rdata      = '0;
    endcase
  end

  // Load data is only captured on an I/O hit; otherwise the previous value is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_hit <= w_ld_hit;
      if (w_ld_hit) begin
        r_rdata <= w_rdata;
      end
    end
  end

  assign mmio_hit_wb   = r_hit;
  assign mmio_rdata_wb = r_rdata;

endmodule

// File: tb/tb_mmio_ctrl.sv
// tb/tb_mmio_ctrl.sv - directed bench with behavioural model and per-cycle compare for mmio_ctrl
module tb_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_xm, st_xm, inst_retire;
  logic [31:0] addr_xm, wdata_xm;
  logic        uart_tx_valid, uart_tx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_rx_valid, uart_rx_ready;
  logic [7:0]  uart_rx_data;
  logic        stall, mmio_hit_wb;
  logic [31:0] mmio_rdata_wb;

  int checks = 0;
  int failures = 0;

  mmio_ctrl #(.W_SIZE(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ld_xm         (ld_xm),
    .st_xm         (st_xm),
    .addr_xm       (addr_xm),
    .wdata_xm      (wdata_xm),
    .inst_retire   (inst_retire),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_ready (uart_rx_ready),
    .stall         (stall),
    .mmio_hit_wb   (mmio_hit_wb),
    .mmio_rdata_wb (mmio_rdata_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state at the start of each cycle.
  logic        m_full;
  logic [7:0]  m_byte;
  logic [31:0] m_cyc, m_inst, m_rdata;
  logic        m_hit;
  logic [7:0]  exp_q[$];

  function automatic logic m_in_io(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a <= 32'h8000_0FFF) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a)
      32'h8000_0000: return (uart_rx_valid ? 32'd2 : 32'd0) + (m_full ? 32'd0 : 32'd1);
      32'h8000_0004: return 32'(uart_rx_data);
      32'h8000_0010: return m_cyc;
      32'h8000_0014: return m_inst;
      default:       return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 1'b0; m_byte = 8'h00; m_cyc = 0; m_inst = 0;
      m_hit = 1'b0; m_rdata = 0;
      exp_q.delete();
    end else begin
      if (uart_tx_valid && uart_tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected_byte", 32'(uart_tx_data), 32'hFFFF_FFFF);
        else chk("tx_order", 32'(uart_tx_data), 32'(exp_q.pop_front()));
      end
      m_hit = ld_xm && m_in_io(addr_xm);
      if (m_hit) m_rdata = m_read(addr_xm);
      if (st_xm && addr_xm == 32'h8000_0008) begin
        if (!m_full || uart_tx_ready) begin
          exp_q.push_back(wdata_xm[7:0]);
          m_byte = wdata_xm[7:0];
          m_full = 1'b1;
        end
      end else if (m_full && uart_tx_ready) begin
        m_full = 1'b0;
      end
      if (st_xm && addr_xm == 32'h8000_0018) begin
        m_cyc = 0; m_inst = 0;
      end else begin
        m_cyc = m_cyc + 1;
        if (inst_retire) m_inst = m_inst + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("hit_wb", 32'(mmio_hit_wb), 32'(m_hit));
      if (m_hit) chk("rdata_wb", mmio_rdata_wb, m_rdata);
      chk("tx_valid", 32'(uart_tx_valid), 32'(m_full));
      if (m_full) chk("tx_data", 32'(uart_tx_data), 32'(m_byte));
      chk("stall", 32'(stall),
          32'(st_xm && addr_xm == 32'h8000_0008 && m_full && !uart_tx_ready));
      chk("rx_ready", 32'(uart_rx_ready),
          32'(ld_xm && addr_xm == 32'h8000_0004 && uart_rx_valid));
    end
  end

  task automatic bus(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] d);
    ld_xm = ld; st_xm = st; addr_xm = a; wdata_xm = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst_retire = 1'b0; uart_tx_ready = 1'b0;
    uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    bus(0, 0, 32'h0, 32'h0);
    tick(); tick();
    chk("reset_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_hit", 32'(mmio_hit_wb), 32'd0);
    chk("reset_rdata", mmio_rdata_wb, 32'd0);
    rst_n = 1'b1;
    tick();

    bus(1, 0, 32'h8000_0000, 0); tick(); bus(0, 0, 0, 0);
    chk("status_after_reset", mmio_rdata_wb, 32'h1);
    chk("status_hit", 32'(mmio_hit_wb), 32'd1);

    bus(0, 1, 32'h8000_0008, 32'h41); #1;
    chk("first_store_no_stall", 32'(stall), 32'd0);
    tick();
    bus(0, 1, 32'h8000_0008, 32'h42); #1;
    chk("second_store_stalls", 32'(stall), 32'd1);
    tick(); tick();
    chk("still_stalled", 32'(stall), 32'd1);
    uart_tx_ready = 1'b1; #1;
    chk("stall_released", 32'(stall), 32'd0);
    tick();
    bus(0, 0, 0, 0); uart_tx_ready = 1'b0;
    chk("buffer_holds_0x42", 32'(uart_tx_data), 32'h42);
    uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;
    chk("buffer_drained", 32'(uart_tx_valid), 32'd0);

    bus(0, 1, 32'h8000_0008, 32'h10); tick();
    bus(0, 1, 32'h8000_0008, 32'h20); uart_tx_ready = 1'b1; #1;
    chk("replace_no_stall", 32'(stall), 32'd0);
    tick();
    bus(0, 0, 0, 0); uart_tx_ready = 1'b0;
    chk("replace_new_byte", 32'(uart_tx_data), 32'h20);
    chk("replace_still_full", 32'(uart_tx_valid), 32'd1);
    uart_rx_valid = 1'b1; bus(1, 0, 32'h8000_0000, 0); tick();
    bus(0, 0, 0, 0); uart_rx_valid = 1'b0;
    chk("status_full_rx", mmio_rdata_wb, 32'h2);
    uart_tx_ready = 1'b1; tick(); uart_tx_ready = 1'b0;

    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; bus(1, 0, 32'h8000_0004, 0); #1;
    chk("rx_ready_pulse", 32'(uart_rx_ready), 32'd1);
    tick();
    bus(0, 0, 0, 0); uart_rx_valid = 1'b0; #1;
    chk("rx_ready_drops", 32'(uart_rx_ready), 32'd0);
    chk("rx_data", mmio_rdata_wb, 32'h5A);
    uart_rx_data = 8'h33; bus(1, 0, 32'h8000_0004, 0); #1;
    chk("rx_no_valid_no_ready", 32'(uart_rx_ready), 32'd0);
    tick(); bus(0, 0, 0, 0);
    chk("rx_data_no_valid", mmio_rdata_wb, 32'h33);

    bus(1, 0, 32'h8000_000C, 0); tick(); bus(0, 0, 0, 0);
    chk("unmapped_hit", 32'(mmio_hit_wb), 32'd1);
    chk("unmapped_zero", mmio_rdata_wb, 32'd0);
    bus(1, 0, 32'h8000_0005, 0); tick(); bus(0, 0, 0, 0);
    chk("misaligned_no_hit", 32'(mmio_hit_wb), 32'd0);
    bus(1, 0, 32'h1000_0010, 0); tick(); bus(0, 0, 0, 0);
    chk("outside_no_hit", 32'(mmio_hit_wb), 32'd0);
    bus(0, 1, 32'h8000_001C, 32'hAB); tick(); bus(0, 0, 0, 0);
    chk("unmapped_store_ignored", 32'(uart_tx_valid), 32'd0);

    bus(0, 1, 32'h8000_0018, 32'hDEAD); tick(); bus(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i < 40);
      tick();
    end
    inst_retire = 1'b0;
    bus(1, 0, 32'h8000_0010, 0); tick();
    chk("cycle_count_100", mmio_rdata_wb, 32'd100);
    bus(1, 0, 32'h8000_0014, 0); tick();
    chk("instret_count_40", mmio_rdata_wb, 32'd40);
    bus(0, 1, 32'h8000_0018, 0); tick();
    bus(0, 0, 0, 0); tick();
    bus(1, 0, 32'h8000_0010, 0); tick();
    chk("cycle_after_clear", mmio_rdata_wb, 32'd1);
    bus(1, 0, 32'h8000_0014, 0); tick(); bus(0, 0, 0, 0);
    chk("instret_after_clear", mmio_rdata_wb, 32'd0);

    bus(0, 1, 32'h8000_0008, 32'h55); tick();
    bus(0, 1, 32'h8000_0008, 32'h66); #1;
    chk("prereset_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("async_reset_stall", 32'(stall), 32'd0);
    chk("async_reset_tx_valid", 32'(uart_tx_valid), 32'd0);
    bus(0, 0, 0, 0);
    tick(); rst_n = 1'b1;
    tick();
    bus(1, 0, 32'h8000_0010, 0); tick(); bus(0, 0, 0, 0);
    chk("cycle_after_reset", mmio_rdata_wb, 32'd1);

    uart_tx_ready = 1'b1; tick(); tick(); uart_tx_ready = 1'b0;
    chk("tx_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller in the execute/memory (X/M) stage. It decodes X/M-stage loads and stores that target the I/O window at 0x8000_0000 and owns the I/O resources behind it:
- a one-entry UART transmit holding buffer with ready/valid handoff;
- a UART receive read path;
- the cycle and retired-instruction counters.

It stalls the pipeline only when a transmit store finds the holding buffer occupied. It returns registered load data to the writeback mux one cycle later.

## Interface
- W_SIZE, 32, datapath width.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ld_xm  in  1  valid load instruction in X/M.
- st_xm  in  1  valid store instruction in X/M.
- addr_xm  in  W_SIZE  ALU-computed effective address.
- wdata_xm  in  W_SIZE  store data (rs2, forwarded).
- inst_retire  in  1  one instruction commits this cycle.
- uart_tx_valid  out  1  holding buffer full, offered to the UART.
- uart_tx_data  out  8  holding buffer byte.
- uart_tx_ready  in  1  UART accepts the byte.
- uart_rx_valid  in  1  UART has a received byte.
- uart_rx_data  in  8  received byte.
- uart_rx_ready  out  1  consume the received byte.
- stall  out  1  freeze PC and the F/D and X/M registers this cycle.
- mmio_hit_wb  out  1  the previous-cycle load targeted a mapped I/O address.
- mmio_rdata_wb  out  W_SIZE  registered load data for writeback.

## Operation
Address map (exact word compare; the low 2 address bits must be 0, otherwise no hit):
- 0x8000_0000 status (read): bit0 = tx buffer empty, bit1 = uart_rx_valid, other bits 0.
- 0x8000_0004 rx data (read): {24'b0, uart_rx_data}. uart_rx_ready = 1 in the same cycle iff uart_rx_valid.
  - If uart_rx_valid = 0, the read returns {24'b0, uart_rx_data} and no handshake occurs.
- 0x8000_0008 tx data (write): stores wdata_xm[7:0] into the holding buffer.
- 0x8000_0010 cycle counter (read).
- 0x8000_0014 retired-instruction counter (read).
- 0x8000_0018 counter reset (write, data ignored).

Unmapped addresses in the window: a load returns 0 with mmio_hit_wb = 1; a store is ignored.

Transmit buffer FSM, states EMPTY and FULL:
- EMPTY, tx store: latch the byte, go to FULL; stall = 0.
- FULL, uart_tx_ready = 1: handshake; go to EMPTY, unless a tx store occurs in the same cycle.
- FULL, tx store with uart_tx_ready = 0: stall = 1. The store is re-presented every cycle until accepted.
- FULL, tx store with uart_tx_ready = 1: the old byte leaves, the new byte is latched, state stays FULL, stall = 0.
- uart_tx_valid = (state == FULL). uart_tx_data holds its value while FULL.

Counters (32-bit, wrap 0xFFFF_FFFF → 0):
- The cycle counter increments every cycle, including stalled cycles.
- The retired-instruction counter increments when inst_retire = 1.
- A counter-reset store loads 0 into both counters; reset wins over increment on that cycle.

stall and uart_rx_ready are combinational from the X/M inputs and the FSM state. Everything else is registered.

## Timing
- Reset values: FSM = EMPTY, buffer = 0, both counters = 0, mmio_hit_wb = 0, mmio_rdata_wb = 0. Hence uart_tx_valid = 0 and stall = 0 (no store presented).
- A load in cycle N produces mmio_hit_wb and mmio_rdata_wb in cycle N+1.
  - Counter reads return the value before any increment made in cycle N.
  - A status read reflects the FSM state at the start of cycle N.
- A tx store accepted in cycle N drives uart_tx_valid = 1 from cycle N+1.
- rx data is consumed in the cycle of the load. The UART must present its next byte, if any, no earlier than N+1.
- Reset asserted mid-stall: the buffer byte is discarded and stall drops immediately (asynchronous).
- Holding register update rules:
  - On a non-load cycle, mmio_rdata_wb holds its value.
  - mmio_hit_wb is registered every cycle; it is 0 after a non-I/O load or a non-load.

## Structure
- Package mmio_pkg holds:
  - the address constants (STATUS, RX, TX, CYC, INSTRET, CNT_RST);
  - the status bit indices;
  - the FSM state encoding (EMPTY = 0, FULL = 1).
- Sub-module mmio_counters: the two counters, their increment enables and the synchronous clear.
- The top level holds the address decode, the tx FSM/buffer, the rx handshake and the read mux/register.

## Test plan
- Reset, then load 0x8000_0000 with uart_rx_valid = 0 → mmio_rdata_wb = 0x1 next cycle; uart_tx_valid = 0.
- Store 0x41 to 0x8000_0008 with uart_tx_ready = 0, then store 0x42 → no stall on the first store; stall = 1 on the second until uart_tx_ready = 1; 0x41 is sent before 0x42, and no byte is lost or duplicated.
- FULL state, tx store in the same cycle as uart_tx_ready = 1 → stall = 0; the next uart_tx_data is the new byte.
- uart_rx_valid = 1, uart_rx_data = 0x5A, load 0x8000_0004 → uart_rx_ready pulses for 1 cycle; mmio_rdata_wb = 0x0000_005A.
- Run 100 cycles with inst_retire high on 40 of them, then store to 0x8000_0018 → the read-back before the clear matches the counts; immediately after, the cycle counter = 1 and instret = 0 (or 1 if inst_retire was high on the read cycle).
- Force the cycle counter near 0xFFFF_FFFF, or assert rst_n low while stalled → the counter wraps to 0; on reset, stall and uart_tx_valid drop in the same cycle.
